// File: rtl/idma_req_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the iDMA request arbiter.
package idma_req_arbiter_pkg;

    localparam int unsigned MaxReq  = 16;
    localparam int unsigned MaxIdxW = 4;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // First valid index at or after ptr, wrapping modulo num; returns ptr if none is valid.
    function automatic logic [MaxIdxW-1:0] rr_pick(input logic [MaxReq-1:0]  valid,
                                                   input logic [MaxIdxW-1:0] ptr,
                                                   input int unsigned        num);
        logic [MaxIdxW-1:0] pick;
        logic [MaxIdxW-1:0] idx;
        logic               found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            idx = MaxIdxW'((32'(ptr) + k) % num);
            if ((k < num) && !found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/idma_req_arbiter_fifo.sv
// Ownership FIFO (non fall-through): records the requester index of each accepted request.
module idma_req_arbiter_fifo #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = AddrW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AddrW-1:0]      r_wptr;
    logic [AddrW-1:0]      r_rptr;
    logic [CntW-1:0]       r_cnt;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full_o    = (r_cnt == CntW'(DEPTH));
    assign empty_o   = (r_cnt == '0);
    assign data_o    = r_mem[r_rptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AddrW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AddrW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/idma_req_arbiter.sv
// Round-robin arbiter sharing one iDMA backend among NumReq requesters; in-order
// responses are routed back to their owner via the ownership FIFO.
module idma_req_arbiter
    import idma_req_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned MaxInFlight = 8,
    parameter type         idma_req_t  = logic,
    parameter type         idma_rsp_t  = logic,
    localparam int unsigned CntW       = $clog2(MaxInFlight + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  idma_req_t [NumReq-1:0]           req_i,
    input  logic      [NumReq-1:0]           req_valid_i,
    output logic      [NumReq-1:0]           req_ready_o,
    output idma_rsp_t [NumReq-1:0]           rsp_o,
    output logic      [NumReq-1:0]           rsp_valid_o,
    input  logic      [NumReq-1:0]           rsp_ready_i,
    output idma_req_t                        be_req_o,
    output logic                             be_req_valid_o,
    input  logic                             be_req_ready_i,
    input  idma_rsp_t                        be_rsp_i,
    input  logic                             be_rsp_valid_i,
    output logic                             be_rsp_ready_o,
    output logic      [NumReq-1:0][CntW-1:0] outstanding_o,
    output logic                             busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    lock_state_e                  r_state;
    lock_state_e                  w_state_nxt;
    logic [IdxW-1:0]              r_lock_idx;
    logic [IdxW-1:0]              r_rr;
    logic [NumReq-1:0][CntW-1:0]  r_outstanding;
    logic [MaxIdxW-1:0]           w_pick;
    logic [IdxW-1:0]              w_win;
    logic [IdxW-1:0]              w_head;
    logic                         w_any;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;

    // A held lock overrides the round-robin pick until the backend accepts.
    assign w_pick = rr_pick(MaxReq'(req_valid_i), MaxIdxW'(r_rr), NumReq);
    assign w_win  = (r_state == LOCK_HELD) ? r_lock_idx : IdxW'(w_pick);
    assign w_any  = |req_valid_i;

    assign be_req_o       = req_i[w_win];
    assign be_req_valid_o = rst_ni && w_any && !w_full;
    assign w_push         = be_req_valid_o && be_req_ready_i;
    assign w_pop          = be_rsp_valid_i && be_rsp_ready_o;
    assign busy_o         = !w_empty;
    assign outstanding_o  = r_outstanding;

    always_comb begin
        req_ready_o        = '0;
        rsp_valid_o        = '0;
        rsp_o              = '0;
        be_rsp_ready_o     = 1'b0;
        req_ready_o[w_win] = be_req_valid_o && be_req_ready_i;
        rsp_valid_o[w_head] = be_rsp_valid_i && !w_empty;
        be_rsp_ready_o     = rsp_ready_i[w_head] && !w_empty;
        for (int i = 0; i < int'(NumReq); i++) begin
            rsp_o[i] = be_rsp_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOCK_FREE: if (be_req_valid_o && !be_req_ready_i) w_state_nxt = LOCK_HELD;
            LOCK_HELD: if (w_push) w_state_nxt = LOCK_FREE;
            default:   w_state_nxt = LOCK_FREE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= LOCK_FREE;
            r_lock_idx <= '0;
            r_rr       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == LOCK_FREE) && (w_state_nxt == LOCK_HELD)) r_lock_idx <= w_win;
            if (w_push) r_rr <= (w_win == IdxW'(NumReq - 1)) ? '0 : w_win + IdxW'(1);
        end
    end

    // Per-requester in-flight count; simultaneous push and pop of one lane cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                case ({w_push && (w_win == IdxW'(i)), w_pop && (w_head == IdxW'(i))})
                    2'b10:   r_outstanding[i] <= r_outstanding[i] + CntW'(1);
                    2'b01:   r_outstanding[i] <= r_outstanding[i] - CntW'(1);
                    default: r_outstanding[i] <= r_outstanding[i];
                endcase
            end
        end
    end

    idma_req_arbiter_fifo #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MaxInFlight)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (w_win),
        .push_i  (w_push),
        .data_o  (w_head),
        .pop_i   (w_pop)
    );

    a_rsp_without_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(be_rsp_valid_i && w_empty));

endmodule

// File: tb/tb_idma_req_arbiter.sv
// Bench for idma_req_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based ownership model.
module tb_idma_req_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
    typedef logic [15:0] req_t;
    typedef logic [7:0]  rsp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    req_t [N-1:0]        req_i;
    logic [N-1:0]        req_valid_i;
    logic [N-1:0]        req_ready_o;
    rsp_t [N-1:0]        rsp_o;
    logic [N-1:0]        rsp_valid_o;
    logic [N-1:0]        rsp_ready_i;
    req_t                be_req_o;
    logic                be_req_valid_o;
    logic                be_req_ready_i;
    rsp_t                be_rsp_i;
    logic                be_rsp_valid_i;
    logic                be_rsp_ready_o;
    logic [N-1:0][3:0]   outstanding_o;
    logic                busy_o;

    idma_req_arbiter #(
        .NumReq      (N),
        .MaxInFlight (D),
        .idma_req_t  (req_t),
        .idma_rsp_t  (rsp_t)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .rsp_o          (rsp_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .be_req_o       (be_req_o),
        .be_req_valid_o (be_req_valid_o),
        .be_req_ready_i (be_req_ready_i),
        .be_rsp_i       (be_rsp_i),
        .be_rsp_valid_i (be_rsp_valid_i),
        .be_rsp_ready_o (be_rsp_ready_o),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Model: owners of accepted-but-unanswered requests in acceptance order.
    int q[$];
    int m_rr;
    int m_lock;
    int acc_lane;
    bit popped;
    int n_chk;
    int n_pass;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_rr     = 0;
        m_lock   = -1;
        acc_lane = -1;
        popped   = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare outputs with the model at the current (negedge) time, then advance one cycle.
    task automatic step();
        int         win;
        int         head;
        int         idx;
        bit         any;
        bit         full;
        bit         empty;
        bit         e_bv;
        bit         e_brr;
        logic [3:0] e_rr;
        logic [3:0] e_rv;
        logic [3:0] cnt;
        logic [1:0] w2;
        any   = |req_valid_i;
        full  = (q.size() == D);
        empty = (q.size() == 0);
        win   = -1;
        if (m_lock >= 0) win = m_lock;
        else for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && req_valid_i[idx]) win = idx;
        end
        e_bv = any && !full;
        e_rr = '0;
        w2   = 2'(win);
        if (e_bv && be_req_ready_i) e_rr[w2] = 1'b1;
        head  = empty ? 0 : q[0];
        e_rv  = '0;
        if (!empty && be_rsp_valid_i) e_rv[2'(head)] = 1'b1;
        e_brr = !empty && rsp_ready_i[2'(head)];

        chk("be_req_valid", 32'(be_req_valid_o), 32'(e_bv));
        if (e_bv) chk("be_req_payload", 32'(be_req_o), 32'(req_i[w2]));
        chk("req_ready", 32'(req_ready_o), 32'(e_rr));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
        chk("be_rsp_ready", 32'(be_rsp_ready_o), 32'(e_brr));
        if (!empty && be_rsp_valid_i) chk("rsp_payload", 32'(rsp_o[2'(head)]), 32'(be_rsp_i));
        chk("busy", 32'(busy_o), 32'(!empty));
        for (int i = 0; i < N; i++) begin
            cnt = '0;
            foreach (q[j]) if (q[j] == i) cnt++;
            chk($sformatf("outstanding[%0d]", i), 32'(outstanding_o[i]), 32'(cnt));
        end

        acc_lane = (e_bv && be_req_ready_i) ? win : -1;
        popped   = be_rsp_valid_i && e_brr;
        @(posedge clk);
        if (popped) void'(q.pop_front());
        if (acc_lane >= 0) begin
            q.push_back(acc_lane);
            m_rr   = (acc_lane + 1) % N;
            m_lock = -1;
        end else if (e_bv) begin
            m_lock = win;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        step();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b0;
        rsp_ready_i    = '0;
        be_req_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] g_exp [5];
    logic [31:0] r;

    initial begin
        n_chk = 0;
        n_pass = 0;
        g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // Reset with every requester valid and the backend ready: nothing may leak out.
        rst_n          = 1'b0;
        req_valid_i    = 4'hF;
        be_req_ready_i = 1'b1;
        be_rsp_valid_i = 1'b0;
        be_rsp_i       = '0;
        rsp_ready_i    = 4'hF;
        for (int i = 0; i < N; i++) req_i[i] = 16'($urandom);
        #2;
        chk("rst_be_req_valid", 32'(be_req_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_be_rsp_ready", 32'(be_rsp_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n       = 1'b1;
        req_valid_i = '0;
        @(posedge clk);
        #1;

        // Lock: requester 2 keeps the grant while 0 arrives during backpressure.
        req_i[2] = 16'hAA02;
        req_i[0] = 16'hAA00;
        be_req_ready_i = 1'b0;
        req_valid_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_valid_i[0] = 1'b1;
            settle();
            chk("lock_payload", 32'(be_req_o), 32'h0000_AA02);
            chk("lock_ready", 32'(req_ready_o), 32'd0);
            step();
        end
        be_req_ready_i = 1'b1;
        settle();
        chk("lock_grant2", 32'(req_ready_o), 32'b0100);
        step();
        req_valid_i = 4'b0001;
        settle();
        chk("after_lock_payload", 32'(be_req_o), 32'h0000_AA00);
        chk("after_lock_grant0", 32'(req_ready_o), 32'b0001);
        step();
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b1;
        be_rsp_i       = 8'h52;
        settle();
        chk("rsp_lane2", 32'(rsp_valid_o), 32'b0100);
        chk("rsp_lane2_payload", 32'(rsp_o[2]), 32'h52);
        step();
        be_rsp_i = 8'h50;
        settle();
        chk("rsp_lane0", 32'(rsp_valid_o), 32'b0001);
        step();
        be_rsp_valid_i = 1'b0;
        cyc();

        // Round-robin over all four requesters from reset, wrapping 3 -> 0.
        do_reset();
        be_req_ready_i = 1'b1;
        rsp_ready_i    = 4'hF;
        req_valid_i    = 4'hF;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("rr_grant%0d", c), 32'(req_ready_o), 32'(g_exp[c]));
            step();
        end
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b1;
        settle();
        chk("rr_rsp0", 32'(rsp_valid_o), 32'b0001);
        step();
        settle();
        chk("rr_rsp1", 32'(rsp_valid_o), 32'b0010);
        step();
        be_rsp_valid_i = 1'b0;

        // Reset with three requests in flight.
        req_valid_i = 4'hF;
        settle();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
        chk("midrst_be_req_valid", 32'(be_req_valid_o), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_grant0", 32'(req_ready_o), 32'b0001);
        step();
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b1;
        cyc();
        be_rsp_valid_i = 1'b0;

        // Fill the ownership FIFO; a same-cycle pop must not admit the ninth request.
        req_valid_i = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            req_i[1] = 16'hB000 + 16'(c);
            settle();
            chk("fill_ready", 32'(req_ready_o), 32'b0010);
            step();
        end
        be_rsp_valid_i = 1'b1;
        settle();
        chk("full_ready", 32'(req_ready_o), 32'd0);
        chk("full_be_valid", 32'(be_req_valid_o), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid_o), 32'b0010);
        step();
        be_rsp_valid_i = 1'b0;
        settle();
        chk("unfull_ready", 32'(req_ready_o), 32'b0010);
        step();
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc();
        be_rsp_valid_i = 1'b0;
        settle();
        chk("drained_busy", 32'(busy_o), 32'd0);
        step();

        // Requests 1,3,1 and in-order return; lane 3 stalls its response for 4 cycles.
        req_i[1] = 16'hC001;
        req_valid_i = 4'b0010;
        cyc();
        req_i[3] = 16'hC003;
        req_valid_i = 4'b1000;
        cyc();
        req_valid_i = 4'b0010;
        cyc();
        req_valid_i = '0;
        settle();
        chk("inorder_out1", 32'(outstanding_o[1]), 32'd2);
        chk("inorder_out3", 32'(outstanding_o[3]), 32'd1);
        step();
        be_rsp_valid_i = 1'b1;
        be_rsp_i       = 8'h61;
        settle();
        chk("inorder_rsp1", 32'(rsp_valid_o), 32'b0010);
        step();
        rsp_ready_i = 4'b0111;
        be_rsp_i    = 8'h63;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("stall_be_rsp_ready", 32'(be_rsp_ready_o), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid_o), 32'b1000);
            chk("stall_out1", 32'(outstanding_o[1]), 32'd1);
            step();
        end
        rsp_ready_i = 4'hF;
        settle();
        chk("inorder_rsp3", 32'(rsp_valid_o), 32'b1000);
        chk("inorder_rsp3_ready", 32'(be_rsp_ready_o), 32'd1);
        step();
        be_rsp_i = 8'h65;
        settle();
        chk("inorder_rsp1b", 32'(rsp_valid_o), 32'b0010);
        step();
        be_rsp_valid_i = 1'b0;
        settle();
        chk("inorder_out1_done", 32'(outstanding_o[1]), 32'd0);
        chk("inorder_busy_done", 32'(busy_o), 32'd0);
        step();

        // Randomized traffic: slow backend responses first (FIFO fills), then fast.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_i[i] || acc_lane == i) begin
                    req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    req_i[i]       = 16'($urandom);
                end
            end
            be_req_ready_i = ($urandom_range(0, 3) != 0);
            if (!be_rsp_valid_i || popped) begin
                be_rsp_valid_i = (q.size() > 0) && ($urandom_range(0, 3) < ((c < 1500) ? 1 : 3));
                be_rsp_i       = 8'($urandom);
            end
            r = $urandom;
            rsp_ready_i = r[3:0] | r[7:4];
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
